// File: rtl/fractal_pkg.sv
// Shared definitions for the fractal framebuffer writer: FSM states,
// colour-mode encodings and the iteration-to-RGB444 colour mapping.
package fractal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic COLOR_MONO = 1'b0;
  localparam logic COLOR_GRAD = 1'b1;

  // Map one engine result to an RGB444+pad word. The gradient scrambles the
  // iteration nibbles so neighbouring counts land on visibly different hues.
  // iter is the count zero-extended to 12 bits; bits above 11 are not shown.
  function automatic logic [15:0] color_map(input logic mode, input logic in_set,
                                            input logic [11:0] iter);
    logic [15:0] word;
    if (mode == COLOR_MONO) begin
      word = {16{in_set}};
    end else if (in_set) begin
      word = 16'h0000;
    end else begin
      word = {iter[3:0], iter[7:4], iter[11:8], 4'h0};
    end
    return word;
  endfunction

endpackage

// File: rtl/fractal_fb_writer_fifo.sv
// fb_sync_fifo: single-clock result FIFO with fall-through read, occupancy
// count and synchronous flush. A push while full is refused even when a pop
// happens on the same edge.
module fb_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and count update; flush returns everything to empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fractal_fb_writer.sv
// fractal_fb_writer: queues fractal engine results and writes them to SRAM
// during video blanking; otherwise addresses SRAM for display readout. Also
// provides a full-memory clear sweep with a completion pulse.
module fractal_fb_writer import fractal_pkg::*; #(
  parameter int              COORD_W     = 10,
  parameter int              DATA_W      = 16,
  parameter int              ITER_W      = 11,
  parameter int              FIFO_DEPTH  = 16,
  parameter int              X_OFFSET    = 500,
  parameter int              Y_OFFSET    = 200,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = 16'hFFFF,
  parameter bit              CLIP        = 1'b0
) (
  input  logic                          VGA_CTRL_CLK,
  input  logic                          reset_n,
  input  logic                          clean_screen,
  input  logic                          start,
  input  logic                          color_mode,
  input  logic                          VGA_VS,
  input  logic                          VGA_HS,
  input  logic [11:0]                   current_X,
  input  logic [11:0]                   current_Y,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic [COORD_W-1:0]            pix_x,
  input  logic [COORD_W-1:0]            pix_y,
  input  logic [ITER_W-1:0]             pix_iter,
  input  logic                          pix_in_set,
  output logic                          start_fract,
  output logic                          clear_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  inout  wire  [DATA_W-1:0]             SRAM_DQ,
  output logic [2*COORD_W-1:0]          SRAM_ADDR,
  output logic                          SRAM_WE_N,
  output logic                          SRAM_UB_N,
  output logic                          SRAM_LB_N,
  output logic                          SRAM_CE_N,
  output logic                          SRAM_OE_N,
  output logic [9:0]                    pixel_Red,
  output logic [9:0]                    pixel_Green,
  output logic [9:0]                    pixel_Blue
);

  localparam int ADDR_W  = 2 * COORD_W;
  localparam int ENTRY_W = 2 * COORD_W + ITER_W + 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                we_n_q, we_n_d;
  logic                start_fract_q, start_fract_d;
  logic                clear_done_q, clear_done_d;
  // One extra bit so the sweep can spend a cycle past the last address
  // before signalling completion.
  logic [ADDR_W:0]     sweep_q, sweep_d;

  logic                blank;
  logic                fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]  fifo_rdata;
  logic [COORD_W-1:0]  ent_x, ent_y;
  logic [ITER_W-1:0]   ent_iter;
  logic                ent_in_set;
  logic [COORD_W:0]    sum_x, sum_y;
  logic                unused_bits;

  assign blank      = ~VGA_VS | ~VGA_HS;
  assign pix_ready  = (state_q == ST_RUN) & ~fifo_full;
  assign ent_x      = fifo_rdata[ENTRY_W-1 -: COORD_W];
  assign ent_y      = fifo_rdata[ITER_W+1 +: COORD_W];
  assign ent_iter   = fifo_rdata[1 +: ITER_W];
  assign ent_in_set = fifo_rdata[0];
  assign sum_x      = {1'b0, ent_x} + (COORD_W+1)'(X_OFFSET);
  assign sum_y      = {1'b0, ent_y} + (COORD_W+1)'(Y_OFFSET);
  // Display coordinates arrive 12 bits wide; only the low COORD_W are used.
  assign unused_bits = ^{current_X, current_Y};

  fb_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (VGA_CTRL_CLK),
    .rst_n (reset_n),
    .flush (~clean_screen),
    .push  (pix_valid & pix_ready),
    .wdata ({pix_x, pix_y, pix_iter, pix_in_set}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, SRAM address/data/strobe and pulse generation.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    we_n_d        = 1'b1;
    start_fract_d = 1'b0;
    clear_done_d  = 1'b0;
    sweep_d       = sweep_q;
    fifo_pop      = 1'b0;
    if (!clean_screen) begin
      state_d = ST_CLEAR;
      sweep_d = '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (!sweep_q[ADDR_W]) begin
            addr_d  = sweep_q[ADDR_W-1:0];
            data_d  = CLEAR_COLOR;
            we_n_d  = 1'b0;
            sweep_d = sweep_q + 1'b1;
          end else begin
            clear_done_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
        ST_IDLE, ST_RUN: begin
          if (state_q == ST_IDLE && !start) begin
            state_d       = ST_RUN;
            start_fract_d = 1'b1;
          end
          if (!blank) begin
            addr_d = {current_X[COORD_W-1:0], current_Y[COORD_W-1:0]};
          end else if (state_q == ST_RUN && !fifo_empty) begin
            fifo_pop = 1'b1;
            // An off-screen entry is consumed without touching memory.
            if (!(CLIP && (sum_x[COORD_W] || sum_y[COORD_W]))) begin
              addr_d = {sum_x[COORD_W-1:0], sum_y[COORD_W-1:0]};
              data_d = color_map(color_mode, ent_in_set, 12'(ent_iter));
              we_n_d = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control and SRAM interface registers.
  always_ff @(posedge VGA_CTRL_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      we_n_q        <= 1'b1;
      start_fract_q <= 1'b0;
      clear_done_q  <= 1'b0;
      sweep_q       <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      we_n_q        <= we_n_d;
      start_fract_q <= start_fract_d;
      clear_done_q  <= clear_done_d;
      sweep_q       <= sweep_d;
    end
  end

  assign SRAM_DQ     = we_n_q ? {DATA_W{1'bz}} : data_q;
  assign SRAM_ADDR   = addr_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_UB_N   = 1'b0;
  assign SRAM_LB_N   = 1'b0;
  assign SRAM_CE_N   = 1'b0;
  assign SRAM_OE_N   = 1'b0;
  assign start_fract = start_fract_q;
  assign clear_done  = clear_done_q;
  assign pixel_Red   = {SRAM_DQ[15:12], 6'b0};
  assign pixel_Green = {SRAM_DQ[11:8], 6'b0};
  assign pixel_Blue  = {SRAM_DQ[7:4], 6'b0};

endmodule

// File: tb/tb_fractal_fb_writer.sv
// Directed bench for fractal_fb_writer. Instance a uses the default geometry;
// instance b is a 4-bit-coordinate, clipping variant so a complete clear
// sweep fits in a short run.
module tb_fractal_fb_writer;

  logic        clk = 1'b0;
  logic        reset_n, start, color_mode, vga_vs, vga_hs;
  logic [11:0] cur_x, cur_y;
  logic [10:0] iter;
  logic        in_set;
  logic        cs_a, cs_b, valid_a, valid_b;
  logic [9:0]  x_a, y_a;
  logic [3:0]  x_b, y_b;

  logic        ready_a, sf_a, done_a, we_a;
  logic [4:0]  lvl_a;
  wire  [15:0] dq_a;
  logic [19:0] addr_a;
  logic        ub_a, lb_a, ce_a, oe_a;
  logic [9:0]  red_a, grn_a, blu_a;

  logic        ready_b, sf_b, done_b, we_b;
  logic [4:0]  lvl_b;
  wire  [15:0] dq_b;
  logic [7:0]  addr_b;
  logic        ub_b, lb_b, ce_b, oe_b;
  logic [9:0]  red_b, grn_b, blu_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fractal_fb_writer u_dut_a (
    .VGA_CTRL_CLK(clk), .reset_n(reset_n), .clean_screen(cs_a), .start(start),
    .color_mode(color_mode), .VGA_VS(vga_vs), .VGA_HS(vga_hs),
    .current_X(cur_x), .current_Y(cur_y), .pix_valid(valid_a), .pix_ready(ready_a),
    .pix_x(x_a), .pix_y(y_a), .pix_iter(iter), .pix_in_set(in_set),
    .start_fract(sf_a), .clear_done(done_a), .fifo_level(lvl_a), .SRAM_DQ(dq_a),
    .SRAM_ADDR(addr_a), .SRAM_WE_N(we_a), .SRAM_UB_N(ub_a), .SRAM_LB_N(lb_a),
    .SRAM_CE_N(ce_a), .SRAM_OE_N(oe_a), .pixel_Red(red_a), .pixel_Green(grn_a),
    .pixel_Blue(blu_a)
  );

  fractal_fb_writer #(
    .COORD_W(4), .X_OFFSET(5), .Y_OFFSET(2), .CLIP(1'b1)
  ) u_dut_b (
    .VGA_CTRL_CLK(clk), .reset_n(reset_n), .clean_screen(cs_b), .start(start),
    .color_mode(color_mode), .VGA_VS(vga_vs), .VGA_HS(vga_hs),
    .current_X(cur_x), .current_Y(cur_y), .pix_valid(valid_b), .pix_ready(ready_b),
    .pix_x(x_b), .pix_y(y_b), .pix_iter(iter), .pix_in_set(in_set),
    .start_fract(sf_b), .clear_done(done_b), .fifo_level(lvl_b), .SRAM_DQ(dq_b),
    .SRAM_ADDR(addr_b), .SRAM_WE_N(we_b), .SRAM_UB_N(ub_b), .SRAM_LB_N(lb_b),
    .SRAM_CE_N(ce_b), .SRAM_OE_N(oe_b), .pixel_Red(red_b), .pixel_Green(grn_b),
    .pixel_Blue(blu_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n_wr, n_bad, n_done, last_wr, done_at;
    reset_n = 1'b0; start = 1'b1; color_mode = 1'b0; vga_vs = 1'b1; vga_hs = 1'b1;
    cur_x = '0; cur_y = '0; iter = '0; in_set = 1'b0;
    cs_a = 1'b1; cs_b = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
    x_a = '0; y_a = '0; x_b = '0; y_b = '0;

    // Reset state
    tick(); tick();
    check("rst_we_n", we_a, 1'b1);
    check("rst_addr", addr_a, 20'h0);
    check("rst_level", lvl_a, 5'd0);
    check("rst_ready", ready_a, 1'b0);
    check("rst_start_fract", sf_a, 1'b0);
    check("rst_clear_done", done_a, 1'b0);
    reset_n = 1'b1;

    // Display addressing outside blanking uses only the low coordinate bits
    cur_x = 12'hF23; cur_y = 12'h045;
    tick();
    check("disp_addr", addr_a, {10'h323, 10'h045});
    check("disp_we_n", we_a, 1'b1);

    // Start: one-cycle engine pulse, then RUN accepts results
    start = 1'b0;
    tick();
    check("start_pulse", sf_a, 1'b1);
    start = 1'b1;
    tick();
    check("start_pulse_end", sf_a, 1'b0);
    check("run_ready", ready_a, 1'b1);

    // 17 pushes with no blanking: 16 accepted, no SRAM writes
    n_wr = 0;
    valid_a = 1'b1;
    for (int i = 0; i < 17; i++) begin
      case (i)
        0:       begin x_a = 10'd3;   y_a = 10'd7; iter = 11'h0;   in_set = 1'b1; end
        1:       begin x_a = 10'd3;   y_a = 10'd7; iter = 11'h2A5; in_set = 1'b0; end
        2:       begin x_a = 10'd3;   y_a = 10'd7; iter = 11'h2A5; in_set = 1'b1; end
        3:       begin x_a = 10'd600; y_a = 10'd7; iter = 11'h0;   in_set = 1'b0; end
        default: begin x_a = 10'(i);  y_a = 10'(i); iter = 11'(i); in_set = 1'b0; end
      endcase
      tick();
      if (we_a == 1'b0) n_wr++;
    end
    valid_a = 1'b0;
    check("full_level", lvl_a, 5'd16);
    check("full_ready", ready_a, 1'b0);
    check("full_no_writes", n_wr, 0);

    // Blanking drains one entry per edge with offset addressing
    vga_vs = 1'b0; color_mode = 1'b0;
    tick();
    check("mono_addr", addr_a, {10'd503, 10'd207});
    check("mono_dq", dq_a, 16'hFFFF);
    check("mono_we_n", we_a, 1'b0);
    check("mono_red", red_a, 10'h3C0);
    color_mode = 1'b1;
    tick();
    check("grad_dq", dq_a, 16'h5A20);
    tick();
    check("grad_in_set_dq", dq_a, 16'h0000);
    color_mode = 1'b0;
    tick();
    check("wrap_addr", addr_a, {10'd76, 10'd207});
    check("wrap_dq", dq_a, 16'h0000);
    check("drain_level", lvl_a, 5'd12);

    // Leaving blanking stops writes and returns to display addressing
    vga_vs = 1'b1; cur_x = 12'd5; cur_y = 12'd9;
    tick();
    check("unblank_we_n", we_a, 1'b1);
    check("unblank_addr", addr_a, {10'd5, 10'd9});

    // Drain the remaining 12, then blanking with an empty FIFO holds the address
    vga_hs = 1'b0;
    repeat (12) tick();
    check("last_entry_addr", addr_a, {10'd515, 10'd215});
    tick();
    check("empty_we_n", we_a, 1'b1);
    check("empty_addr_hold", addr_a, {10'd515, 10'd215});
    check("empty_level", lvl_a, 5'd0);
    vga_hs = 1'b1;

    // Reset while running with 5 entries queued
    valid_a = 1'b1;
    repeat (5) tick();
    valid_a = 1'b0;
    check("queued_level", lvl_a, 5'd5);
    reset_n = 1'b0;
    tick();
    check("midrst_we_n", we_a, 1'b1);
    check("midrst_level", lvl_a, 5'd0);
    check("midrst_ready", ready_a, 1'b0);
    reset_n = 1'b1;
    tick();

    // Clear sweep on instance b: 256 writes of FFFF, then one done pulse
    cs_b = 1'b0;
    tick();
    cs_b = 1'b1;
    n_wr = 0; n_bad = 0; n_done = 0; last_wr = -1; done_at = -1;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (we_b == 1'b0) begin
        if (addr_b !== 8'(n_wr) || dq_b !== 16'hFFFF) n_bad++;
        n_wr++;
        last_wr = c;
      end
      if (done_b == 1'b1) begin
        n_done++;
        done_at = c;
      end
    end
    check("clear_writes", n_wr, 256);
    check("clear_bad_writes", n_bad, 0);
    check("clear_done_count", n_done, 1);
    check("clear_done_after_last", done_at, last_wr + 1);

    // Clipping on instance b: overflowing x is popped without a write
    start = 1'b0;
    tick();
    start = 1'b1;
    valid_b = 1'b1; in_set = 1'b1; color_mode = 1'b0;
    x_b = 4'd12; y_b = 4'd1;
    tick();
    x_b = 4'd2; y_b = 4'd3;
    tick();
    valid_b = 1'b0;
    check("clip_queued", lvl_b, 5'd2);
    vga_vs = 1'b0;
    tick();
    check("clip_we_n", we_b, 1'b1);
    check("clip_level", lvl_b, 5'd1);
    tick();
    check("noclip_we_n", we_b, 1'b0);
    check("noclip_addr", addr_b, 8'h75);
    vga_vs = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
